// File: rtl/coeff_lut_bank.sv
// Bank of NUM_COEFF coefficient tables, bulk-loaded word by word and read in parallel at one address.
// Define COEFF_LUT_PARITY_EN to store an even-parity bit per entry and flag mismatches on read.
`timescale 1ns/1ps
module coeff_lut_bank #(
  parameter int NUM_COEFF  = 3,
  parameter int DEPTH      = 3072,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            rst_n,
  input  logic                            ld_start,
  input  logic                            ld_valid,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic                            ld_ready,
  output logic                            ld_done,
  output logic                            busy,
  input  logic                            rd_valid,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_ready,
  output logic                            rd_q_valid,
  output logic [NUM_COEFF*DATA_WIDTH-1:0] rd_q,
  output logic                            rd_err,
  output logic                            rd_parity_err
);

  localparam int SEL_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef COEFF_LUT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int STORE_W = DATA_WIDTH + PAR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_next;
  logic [SEL_W-1:0]      sel, sel_next;
  logic                  up;
  logic                  wr_en;
  logic                  last_word;
  logic [STORE_W-1:0]    store_word;

  logic [STORE_W-1:0]    mem   [NUM_COEFF][DEPTH];
  logic [STORE_W-1:0]    mem_q [NUM_COEFF];

  logic                  rd_fire;
  logic                  in_range;
  logic                  s1_valid;
  logic                  s1_oor;
  logic [NUM_COEFF*DATA_WIDTH-1:0] data_cat;
  logic                  par_fail;

  assign last_word = (sel == SEL_W'(NUM_COEFF - 1)) && (word_cnt == ADDR_WIDTH'(DEPTH - 1));

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    sel_next      = sel;
    wr_en         = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_next    = LOAD;
          word_cnt_next = '0;
          sel_next      = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          if (last_word) begin
            state_next = DONE;
          end else if (word_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            word_cnt_next = '0;
            sel_next      = sel + 1'b1;
          end else begin
            word_cnt_next = word_cnt + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      sel      <= '0;
      up       <= 1'b0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      sel      <= sel_next;
      up       <= 1'b1;
    end
  end

  // 'up' keeps rd_ready low while reset is held even though the state is IDLE.
  assign ld_ready = (state == LOAD);
  assign ld_done  = (state == DONE);
  assign busy     = (state != IDLE);
  assign rd_ready = (state == IDLE) && up;

`ifdef COEFF_LUT_PARITY_EN
  assign store_word = {^ld_data, ld_data};
`else
  assign store_word = ld_data;
`endif

  // NOTE: table storage has no reset; clearing it would forbid RAM inference and isn't needed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[sel][word_cnt[IDX_W-1:0]] <= store_word;
  end

  assign rd_fire  = rd_valid && rd_ready;
  assign in_range = {1'b0, rd_addr} < (ADDR_WIDTH + 1)'(DEPTH);

  // Synchronous RAM read; out-of-range requests never touch the array.
  always_ff @(posedge clock) begin
    if (rd_fire && in_range) begin
      for (int k = 0; k < NUM_COEFF; k++) mem_q[k] <= mem[k][rd_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      s1_oor   <= !in_range;
    end
  end

  always_comb begin
    data_cat = '0;
    par_fail = 1'b0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      data_cat[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][DATA_WIDTH-1:0];
`ifdef COEFF_LUT_PARITY_EN
      par_fail = par_fail | (^mem_q[k]);
`endif
    end
  end

  // rd_q only loads on a result, so it holds between results; flags are cleared otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_q_valid    <= 1'b0;
      rd_q          <= '0;
      rd_err        <= 1'b0;
      rd_parity_err <= 1'b0;
    end else begin
      rd_q_valid    <= s1_valid;
      rd_err        <= s1_valid && s1_oor;
      rd_parity_err <= s1_valid && !s1_oor && par_fail;
      if (s1_valid) rd_q <= s1_oor ? '0 : data_cat;
    end
  end

endmodule
